// File: rtl/rom_verilog.sv
// Read-only program memory holding (operator, operand) pairs for the puzzle solvers.
// Registered outputs give one cycle of read latency; unpopulated addresses read as HALT.
module rom_verilog #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int PROG_LEN   = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] read_operator,
    output logic [DATA_WIDTH-1:0] read_operand
);

    localparam logic [DATA_WIDTH-1:0] OP_HALT  = DATA_WIDTH'(16'h0000);
    localparam logic [DATA_WIDTH-1:0] OP_LEFT  = DATA_WIDTH'(16'h0001);
    localparam logic [DATA_WIDTH-1:0] OP_RIGHT = DATA_WIDTH'(16'h0002);

    logic                  in_range;
    logic [DATA_WIDTH-1:0] rom_operator;
    logic [DATA_WIDTH-1:0] rom_operand;

    // The whole address is decoded, so high addresses never alias onto the program.
    assign in_range = (int'(addr) < PROG_LEN);

    always_comb begin
        rom_operator = OP_HALT;
        rom_operand  = '0;
        if (in_range) begin
            case (addr)
                ADDR_WIDTH'(0):  begin rom_operator = OP_LEFT;  rom_operand = DATA_WIDTH'(16'h0044); end
                ADDR_WIDTH'(1):  begin rom_operator = OP_LEFT;  rom_operand = DATA_WIDTH'(16'h001E); end
                ADDR_WIDTH'(2):  begin rom_operator = OP_RIGHT; rom_operand = DATA_WIDTH'(16'h0030); end
                ADDR_WIDTH'(3):  begin rom_operator = OP_LEFT;  rom_operand = DATA_WIDTH'(16'h0005); end
                ADDR_WIDTH'(4):  begin rom_operator = OP_RIGHT; rom_operand = DATA_WIDTH'(16'h003C); end
                ADDR_WIDTH'(5):  begin rom_operator = OP_LEFT;  rom_operand = DATA_WIDTH'(16'h0037); end
                ADDR_WIDTH'(6):  begin rom_operator = OP_LEFT;  rom_operand = DATA_WIDTH'(16'h0001); end
                ADDR_WIDTH'(7):  begin rom_operator = OP_LEFT;  rom_operand = DATA_WIDTH'(16'h0063); end
                ADDR_WIDTH'(8):  begin rom_operator = OP_RIGHT; rom_operand = DATA_WIDTH'(16'h000E); end
                ADDR_WIDTH'(9):  begin rom_operator = OP_LEFT;  rom_operand = DATA_WIDTH'(16'h0052); end
                ADDR_WIDTH'(10): begin rom_operator = OP_HALT;  rom_operand = DATA_WIDTH'(16'h0000); end
                default:         begin rom_operator = OP_HALT;  rom_operand = '0; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_operator <= '0;
            read_operand  <= '0;
        end else begin
            read_operator <= rom_operator;
            read_operand  <= rom_operand;
        end
    end

endmodule

// File: tb/tb_rom_verilog.sv
// Directed self-checking bench for rom_verilog: reset, sequential reads, latency,
// boundary addresses, asynchronous reset mid-stream and hold.
module tb_rom_verilog;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] read_operator;
    logic [15:0] read_operand;

    int total_count;
    int bad_count;

    rom_verilog #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .PROG_LEN  (11)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .read_operator(read_operator),
        .read_operand (read_operand)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        if (observed !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got op=%h opnd=%h want op=%h opnd=%h",
                     tag, observed[31:16], observed[15:0], expected[31:16], expected[15:0]);
        end
    endtask

    // Drive a new address on the falling edge, then sample just after the rising edge.
    task automatic applyStimulus(input logic [15:0] a);
        @(negedge clk);
        addr = a;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] seq_addr [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    logic [31:0] seq_exp  [6] = '{32'h0001_0044, 32'h0001_001E, 32'h0002_0030,
                                  32'h0001_0005, 32'h0002_003C, 32'h0001_0037};
    logic [15:0] bnd_addr [4] = '{16'h0009, 16'h000A, 16'h000B, 16'hFFFF};
    logic [31:0] bnd_exp  [4] = '{32'h0001_0052, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    initial begin
        total_count = 0;
        bad_count   = 0;
        reset = 1'b1;
        addr  = 16'h0003;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", {read_operator, read_operand}, 32'h0);
        end

        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_release", {read_operator, read_operand}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(seq_addr[i]);
            checkOutput($sformatf("seq_%0d", i), {read_operator, read_operand}, seq_exp[i]);
        end

        applyStimulus(16'h0002);
        checkOutput("lat_before", {read_operator, read_operand}, 32'h0002_0030);
        @(negedge clk);
        addr = 16'h0007;
        #2;
        checkOutput("lat_hold", {read_operator, read_operand}, 32'h0002_0030);
        @(posedge clk);
        #1;
        checkOutput("lat_after", {read_operator, read_operand}, 32'h0001_0063);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(bnd_addr[i]);
            checkOutput($sformatf("bound_%h", bnd_addr[i]), {read_operator, read_operand}, bnd_exp[i]);
        end

        applyStimulus(16'h0008);
        checkOutput("pre_async", {read_operator, read_operand}, 32'h0002_000E);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("async_clear", {read_operator, read_operand}, 32'h0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_released", {read_operator, read_operand}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("async_reload", {read_operator, read_operand}, 32'h0002_000E);

        applyStimulus(16'h0001);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("hold_edge_%0d", i), {read_operator, read_operand}, 32'h0001_001E);
            @(negedge clk);
            checkOutput($sformatf("hold_mid_%0d", i), {read_operator, read_operand}, 32'h0001_001E);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
